// File: rtl/uart_autobaud_ctrl.sv
// Autobaud controller: measures the width of a start bit on rx and programs
// the 16x-oversample baud divisor from it, or accepts a manual divisor.
module uart_autobaud_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = 16'd26,
    parameter logic [19:0] MIN_COUNT   = 20'd32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        start,
    input  logic [15:0] man_div,
    input  logic        man_load,
    output logic [15:0] DIVxR,
    output logic        b_en,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_FALL,
        MEASURE,
        APPLY
    } state_t;

    state_t      state, state_n;
    logic [19:0] cnt, cnt_n;
    logic [15:0] div_n;
    logic        b_en_n, done_n, err_n;
    logic        rx_m, rx_s, rx_d;

    // Synchronizer plus one delay stage for edge detection; idle-high on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            DIVxR <= DEFAULT_DIV;
            b_en  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            DIVxR <= div_n;
            b_en  <= b_en_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = DIVxR;
        b_en_n  = b_en;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                // A manual load takes priority and swallows a simultaneous start.
                if (man_load) begin
                    div_n  = man_div;
                    b_en_n = 1'b1;
                end else if (start) begin
                    state_n = WAIT_IDLE;
                    b_en_n  = 1'b0;
                    cnt_n   = '0;
                end
            end
            WAIT_IDLE: begin
                if (rx_s && rx_d)
                    state_n = WAIT_FALL;
            end
            WAIT_FALL: begin
                if (!rx_s && rx_d) begin
                    state_n = MEASURE;
                    cnt_n   = 20'd1;
                end
            end
            MEASURE: begin
                if (rx_s && !rx_d) begin
                    state_n = APPLY;
                end else if (!rx_s) begin
                    if (cnt == '1) begin
                        err_n   = 1'b1;
                        b_en_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 20'd1;
                    end
                end
            end
            APPLY: begin
                if (cnt < MIN_COUNT) begin
                    err_n = 1'b1;
                end else begin
                    // Round N/16 to nearest, then minus one for the tick counter.
                    div_n  = 16'(((21'(cnt) + 21'd8) >> 4) - 21'd1);
                    done_n = 1'b1;
                end
                b_en_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Scoreboard bench for uart_autobaud_ctrl: stimulus pushes expected done/err
// events computed from the pulse width; a monitor pops them as they appear.
module tb_uart_autobaud_ctrl;

    localparam int TIMEOUT_N = 1 << 20;
    localparam int MIN_N     = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        start;
    logic [15:0] man_div;
    logic        man_load;
    logic [15:0] DIVxR;
    logic        b_en;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        bit          is_done;
        logic [15:0] div;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] model_div;

    uart_autobaud_ctrl #(.DEFAULT_DIV(16'd26), .MIN_COUNT(20'd32)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .start    (start),
        .man_div  (man_div),
        .man_load (man_load),
        .DIVxR    (DIVxR),
        .b_en     (b_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: a width below the minimum or at the timeout is an error,
    // otherwise divisor = round(width/16) - 1.
    function automatic void expect_pulse(int low);
        exp_t e;
        if (low < MIN_N || low >= TIMEOUT_N) begin
            e.is_done = 1'b0;
        end else begin
            model_div = 16'(((low + 8) / 16) - 1);
            e.is_done = 1'b1;
        end
        e.div = model_div;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            tests++;
            if (done && err) begin
                fails++;
                $display("FAIL event_overlap: got done=1 err=1 expected one of them");
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got done=%0d err=%0d div=%0d expected none", done, err, DIVxR);
            end else begin
                mon_e = sb.pop_front();
                if (done !== mon_e.is_done || DIVxR !== mon_e.div) begin
                    fails++;
                    $display("FAIL event: got done=%0d div=%0d expected done=%0d div=%0d",
                             done, DIVxR, mon_e.is_done, mon_e.div);
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ben_after_start", 32'(b_en), 32'd0);
    endtask

    task automatic run_pulse(int high, int low, bit mid_load);
        logic [15:0] prev_div;
        pulse_start();
        repeat (high) @(negedge clk);
        prev_div = model_div;
        rx = 1'b0;
        expect_pulse(low);
        for (int i = 0; i < low; i++) begin
            @(negedge clk);
            if (i == low / 2) begin
                check("ben_measure", 32'(b_en), 32'd0);
                if (mid_load) begin
                    man_div  = 16'($urandom);
                    man_load = 1'b1;
                end
            end else if (i == low / 2 + 1 && mid_load) begin
                man_load = 1'b0;
                check("load_ignored_busy", 32'(DIVxR), 32'(prev_div));
            end
        end
        rx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_early_result", 32'(done | err), 32'd0);
        end
        @(negedge clk);
        check("result_latency", 32'(done | err), 32'd1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ben", 32'(b_en), 32'd1);
        check("idle_div", 32'(DIVxR), 32'(model_div));
    endtask

    initial begin
        int waited;
        rst = 1'b1; rx = 1'b1; start = 1'b0; man_load = 1'b0; man_div = '0;
        model_div = 16'd26;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("reset_div", 32'(DIVxR), 32'd26);
        check("reset_ben", 32'(b_en), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        run_pulse(10, 435, 1'b0);
        check("n435_div", 32'(DIVxR), 32'd26);
        run_pulse(10, 10, 1'b0);
        run_pulse(5, 31, 1'b0);
        run_pulse(5, 32, 1'b0);
        check("n32_div", 32'(DIVxR), 32'd1);
        for (int k = 0; k < 6; k++)
            run_pulse(int'($urandom_range(2, 20)), int'($urandom_range(16, 4000)), 1'b0);

        // Timeout: line held low until the counter saturates.
        pulse_start();
        repeat (10) @(negedge clk);
        rx = 1'b0;
        expect_pulse(TIMEOUT_N);
        waited = 0;
        while (busy && waited < TIMEOUT_N + 100) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_cycles", 32'(waited), 32'(TIMEOUT_N + 2));
        check("timeout_ben", 32'(b_en), 32'd1);
        check("timeout_div", 32'(DIVxR), 32'(model_div));
        rx = 1'b1;
        repeat (5) @(negedge clk);

        @(negedge clk) begin man_div = 16'd100; man_load = 1'b1; end
        @(negedge clk) man_load = 1'b0;
        model_div = 16'd100;
        check("man_load_idle", 32'(DIVxR), 32'd100);
        run_pulse(10, 800, 1'b1);

        @(negedge clk) begin
            man_div = 16'($urandom); start = 1'b1; man_load = 1'b1;
        end
        @(negedge clk) begin start = 1'b0; man_load = 1'b0; end
        model_div = man_div;
        check("load_beats_start_div", 32'(DIVxR), 32'(model_div));
        check("load_beats_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("load_beats_start_busy2", 32'(busy), 32'd0);

        // Reset mid-measurement: no event expected, defaults restored.
        pulse_start();
        repeat (10) @(negedge clk);
        rx = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_div = 16'd26;
        @(negedge clk);
        check("abort_div", 32'(DIVxR), 32'd26);
        check("abort_ben", 32'(b_en), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        run_pulse(10, 1600, 1'b0);
        check("n1600_div", 32'(DIVxR), 32'd99);

        repeat (10) @(negedge clk);
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
